ps2_coco_kbd: RTL and testbench

PS2_COCO_KBD -- requirements
Module: ps2_coco_kbd

---
 rtl/ps2_coco_kbd_if.sv | 30 +++
 rtl/ps2_coco_kbd.sv | 167 ++++++++++++++++
 tb/tb_ps2_coco_kbd.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_coco_kbd_if.sv
// Keyboard-side signal bundle for ps2_coco_kbd.
//   ps2_key : {toggle, press, ext, set-2 code} from the PS/2 front end
//   dragon  : 0 = CoCo row layout, 1 = Dragon row layout
//   kb_cols : PIA PB column strobes, active low
//   joy_btn : fire buttons, active high ([0] right, [1] left)
//   kb_rows : PIA PA0..PA6 row returns, active low
// master drives the keyboard/PIA side, slave is the matrix block.
interface ps2_coco_kbd_if;
  logic [10:0] ps2_key;
  logic        dragon;
  logic [7:0]  kb_cols;
  logic [1:0]  joy_btn;
  logic [6:0]  kb_rows;

  modport master (
    output ps2_key,
    output dragon,
    output kb_cols,
    output joy_btn,
    input  kb_rows
  );

  modport slave (
    input  ps2_key,
    input  dragon,
    input  kb_cols,
    input  joy_btn,
    output kb_rows
  );
endinterface

// File: rtl/ps2_coco_kbd.sv
// PS/2 set-2 key events to a CoCo/Dragon 7x8 keyboard matrix.
//   clk   : system clock (clk_sys domain), rising edge
//   reset : synchronous, active high
//   bus   : ps2_coco_kbd_if.slave (ps2_key, dragon, kb_cols, joy_btn in; kb_rows out)
// An event is a change of ps2_key[10]. It is latched on the toggle cycle, decoded and written
// into the matrix on the next cycle, and seen on kb_rows one cycle after that.
module ps2_coco_kbd (
  input  logic           clk,
  input  logic           reset,
  ps2_coco_kbd_if.slave  bus
);

  logic            toggle_q;
  logic            evt_valid_q;
  logic            evt_press_q;
  logic            evt_ext_q;
  logic [7:0]      evt_code_q;
  logic [6:0][7:0] matrix_q, matrix_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic [6:0]      kb_rows_q, kb_rows_d;

  logic            key_event;
  logic [6:0]      dec_loc;      // {hit, row[2:0], col[2:0]}
  logic            dec_lshift;
  logic            dec_rshift;
  logic [6:0][7:0] mat_eff;
  logic [6:0][7:0] mat_phys;

  assign key_event = (toggle_q != bus.ps2_key[10]);

  // Scancode decode; ext is part of the key so E0-prefixed and plain codes never alias.
  always_comb begin
    dec_loc    = 7'd0;
    dec_lshift = 1'b0;
    dec_rshift = 1'b0;
    case ({evt_ext_q, evt_code_q})
      9'h054: dec_loc = {1'b1, 3'd0, 3'd0};
      9'h01C: dec_loc = {1'b1, 3'd0, 3'd1};
      9'h032: dec_loc = {1'b1, 3'd0, 3'd2};
      9'h021: dec_loc = {1'b1, 3'd0, 3'd3};
      9'h023: dec_loc = {1'b1, 3'd0, 3'd4};
      9'h024: dec_loc = {1'b1, 3'd0, 3'd5};
      9'h02B: dec_loc = {1'b1, 3'd0, 3'd6};
      9'h034: dec_loc = {1'b1, 3'd0, 3'd7};
      9'h033: dec_loc = {1'b1, 3'd1, 3'd0};
      9'h043: dec_loc = {1'b1, 3'd1, 3'd1};
      9'h03B: dec_loc = {1'b1, 3'd1, 3'd2};
      9'h042: dec_loc = {1'b1, 3'd1, 3'd3};
      9'h04B: dec_loc = {1'b1, 3'd1, 3'd4};
      9'h03A: dec_loc = {1'b1, 3'd1, 3'd5};
      9'h031: dec_loc = {1'b1, 3'd1, 3'd6};
      9'h044: dec_loc = {1'b1, 3'd1, 3'd7};
      9'h04D: dec_loc = {1'b1, 3'd2, 3'd0};
      9'h015: dec_loc = {1'b1, 3'd2, 3'd1};
      9'h02D: dec_loc = {1'b1, 3'd2, 3'd2};
      9'h01B: dec_loc = {1'b1, 3'd2, 3'd3};
      9'h02C: dec_loc = {1'b1, 3'd2, 3'd4};
      9'h03C: dec_loc = {1'b1, 3'd2, 3'd5};
      9'h02A: dec_loc = {1'b1, 3'd2, 3'd6};
      9'h01D: dec_loc = {1'b1, 3'd2, 3'd7};
      9'h022: dec_loc = {1'b1, 3'd3, 3'd0};
      9'h035: dec_loc = {1'b1, 3'd3, 3'd1};
      9'h01A: dec_loc = {1'b1, 3'd3, 3'd2};
      9'h175: dec_loc = {1'b1, 3'd3, 3'd3};
      9'h172: dec_loc = {1'b1, 3'd3, 3'd4};
      9'h16B: dec_loc = {1'b1, 3'd3, 3'd5};
      9'h066: dec_loc = {1'b1, 3'd3, 3'd5};  // backspace doubles as LEFT
      9'h174: dec_loc = {1'b1, 3'd3, 3'd6};
      9'h029: dec_loc = {1'b1, 3'd3, 3'd7};
      9'h045: dec_loc = {1'b1, 3'd4, 3'd0};
      9'h016: dec_loc = {1'b1, 3'd4, 3'd1};
      9'h01E: dec_loc = {1'b1, 3'd4, 3'd2};
      9'h026: dec_loc = {1'b1, 3'd4, 3'd3};
      9'h025: dec_loc = {1'b1, 3'd4, 3'd4};
      9'h02E: dec_loc = {1'b1, 3'd4, 3'd5};
      9'h036: dec_loc = {1'b1, 3'd4, 3'd6};
      9'h03D: dec_loc = {1'b1, 3'd4, 3'd7};
      9'h03E: dec_loc = {1'b1, 3'd5, 3'd0};
      9'h046: dec_loc = {1'b1, 3'd5, 3'd1};
      9'h052: dec_loc = {1'b1, 3'd5, 3'd2};
      9'h04C: dec_loc = {1'b1, 3'd5, 3'd3};
      9'h041: dec_loc = {1'b1, 3'd5, 3'd4};
      9'h04E: dec_loc = {1'b1, 3'd5, 3'd5};
      9'h049: dec_loc = {1'b1, 3'd5, 3'd6};
      9'h04A: dec_loc = {1'b1, 3'd5, 3'd7};
      9'h05A: dec_loc = {1'b1, 3'd6, 3'd0};
      9'h16C: dec_loc = {1'b1, 3'd6, 3'd1};
      9'h076: dec_loc = {1'b1, 3'd6, 3'd2};
      9'h011: dec_loc = {1'b1, 3'd6, 3'd3};
      9'h014: dec_loc = {1'b1, 3'd6, 3'd4};
      9'h005: dec_loc = {1'b1, 3'd6, 3'd5};
      9'h006: dec_loc = {1'b1, 3'd6, 3'd6};
      9'h012: dec_lshift = 1'b1;
      9'h059: dec_rshift = 1'b1;
      default: dec_loc = 7'd0;
    endcase
  end

  // Matrix write on the cycle after the event was latched.
  always_comb begin
    matrix_d = matrix_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    if (evt_valid_q) begin
      if (dec_lshift) begin
        lshift_d = evt_press_q;
      end else if (dec_rshift) begin
        rshift_d = evt_press_q;
      end else if (dec_loc[6]) begin
        matrix_d[dec_loc[5:3]][dec_loc[2:0]] = evt_press_q;
      end
    end
  end

  // SHIFT is the OR of both shift keys so releasing one keeps it held by the other.
  always_comb begin
    mat_eff       = matrix_q;
    mat_eff[6][7] = matrix_q[6][7] | lshift_q | rshift_q;
  end

  // Dragon moves matrix rows 0..5 up by two physical rows (mod 6); row 6 is shared.
  always_comb begin
    mat_phys = mat_eff;
    for (int p = 0; p < 6; p++) begin
      mat_phys[p] = bus.dragon ? mat_eff[(p + 4) % 6] : mat_eff[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 7; p++) begin
      kb_rows_d[p] = ~|(mat_phys[p] & ~bus.kb_cols);
    end
    if (bus.joy_btn[0]) kb_rows_d[0] = 1'b0;
    if (bus.joy_btn[1]) kb_rows_d[1] = 1'b0;
  end

  // The toggle reference tracks ps2_key[10] even in reset, so a toggle coinciding with
  // reset is absorbed and never seen as an event afterwards.
  always_ff @(posedge clk) begin
    toggle_q <= bus.ps2_key[10];
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_press_q <= 1'b0;
      evt_ext_q   <= 1'b0;
      evt_code_q  <= 8'h00;
      matrix_q    <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      kb_rows_q   <= 7'h7F;
    end else begin
      evt_valid_q <= key_event;
      if (key_event) begin
        evt_press_q <= bus.ps2_key[9];
        evt_ext_q   <= bus.ps2_key[8];
        evt_code_q  <= bus.ps2_key[7:0];
      end
      matrix_q  <= matrix_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      kb_rows_q <= kb_rows_d;
    end
  end

  assign bus.kb_rows = kb_rows_q;

endmodule

// File: tb/tb_ps2_coco_kbd.sv
module tb_ps2_coco_kbd;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] sb[$];
  logic [6:0] exp_rows;

  ps2_coco_kbd_if bus ();

  ps2_coco_kbd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic press, input logic ext, input logic [7:0] code);
    bus.ps2_key = {~bus.ps2_key[10], press, ext, code};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.kb_cols = 8'h00;
    sb.push_back(7'h7F);
    step(2);
    reset = 1'b0;
    step(1);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL reset_rows: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
  endtask

  // A sits at row 0, column 1.
  task automatic test_press_a;
    bus.kb_cols = 8'hFD;
    send_key(1'b1, 1'b0, 8'h1C);
    sb.push_back(7'h7F);
    sb.push_back(7'h7E);
    sb.push_back(7'h7F);
    sb.push_back(7'h7F);
    step(2);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL press_a_latency: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    step(1);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL press_a_col1: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    bus.kb_cols = 8'hFE;
    step(1);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL press_a_col0: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    bus.kb_cols = 8'hFD;
    send_key(1'b1, 1'b0, 8'h1C);
    step(3);
    send_key(1'b0, 1'b0, 8'h1C);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL release_a: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
  endtask

  task automatic test_dragon;
    bus.kb_cols = 8'hFD;
    send_key(1'b1, 1'b0, 8'h1C);
    step(3);
    bus.dragon = 1'b1;
    sb.push_back(7'h7B);
    sb.push_back(7'h7A);
    sb.push_back(7'h7F);
    step(1);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL dragon_a_row2: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b1, 1'b0, 8'h16);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL dragon_1_row0: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b0, 1'b0, 8'h1C);
    step(1);
    send_key(1'b0, 1'b0, 8'h16);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL dragon_release: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    bus.dragon = 1'b0;
  endtask

  task automatic test_shift;
    logic [7:0] codes [4];
    logic       press [4];
    codes = '{8'h12, 8'h59, 8'h12, 8'h59};
    press = '{1'b1, 1'b1, 1'b0, 1'b0};
    bus.kb_cols = 8'h7F;
    sb.push_back(7'h3F);
    sb.push_back(7'h3F);
    sb.push_back(7'h3F);
    sb.push_back(7'h7F);
    for (int i = 0; i < 4; i++) begin
      send_key(press[i], 1'b0, codes[i]);
      step(3);
      exp_rows = sb.pop_front();
      checks++;
      if (bus.kb_rows !== exp_rows) begin
        errors++;
        $display("FAIL shift_step%0d: kb_rows=%h expected=%h", i, bus.kb_rows, exp_rows);
      end
    end
  endtask

  task automatic test_ext;
    bus.kb_cols = 8'hF7;
    sb.push_back(7'h7F);
    sb.push_back(7'h77);
    sb.push_back(7'h77);
    sb.push_back(7'h7F);
    sb.push_back(7'h77);
    send_key(1'b1, 1'b0, 8'h75);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL ext_75_plain: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b1, 1'b1, 8'h75);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL ext_up: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b0, 1'b0, 8'h75);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL ext_plain_release: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b0, 1'b1, 8'h75);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL ext_up_release: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    bus.kb_cols = 8'hDF;
    send_key(1'b1, 1'b0, 8'h66);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL left_bksp: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b0, 1'b0, 8'h66);
    step(3);
  endtask

  task automatic test_unmapped;
    bus.kb_cols = 8'h00;
    sb.push_back(7'h7F);
    send_key(1'b1, 1'b0, 8'h7E);
    step(1);
    send_key(1'b1, 1'b1, 8'h12);
    step(1);
    send_key(1'b1, 1'b0, 8'h00);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL unmapped: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
  endtask

  task automatic test_joystick;
    logic [1:0] btn [4];
    btn = '{2'b01, 2'b10, 2'b11, 2'b00};
    bus.kb_cols = 8'hFF;
    sb.push_back(7'h7E);
    sb.push_back(7'h7D);
    sb.push_back(7'h7C);
    sb.push_back(7'h7F);
    for (int i = 0; i < 4; i++) begin
      bus.joy_btn = btn[i];
      step(1);
      exp_rows = sb.pop_front();
      checks++;
      if (bus.kb_rows !== exp_rows) begin
        errors++;
        $display("FAIL joy_%0d: kb_rows=%h expected=%h", i, bus.kb_rows, exp_rows);
      end
    end
  endtask

  // A (r0c1) and H (r1c0) together, no ghost suppression.
  task automatic test_ghost;
    send_key(1'b1, 1'b0, 8'h1C);
    step(1);
    send_key(1'b1, 1'b0, 8'h33);
    bus.kb_cols = 8'hFC;
    sb.push_back(7'h7C);
    sb.push_back(7'h7D);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL ghost_both: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    bus.kb_cols = 8'hFE;
    step(1);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL ghost_col0: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b0, 1'b0, 8'h1C);
    step(1);
    send_key(1'b0, 1'b0, 8'h33);
    step(3);
  endtask

  task automatic test_back_to_back;
    bus.kb_cols = 8'hF3;
    sb.push_back(7'h7E);
    sb.push_back(7'h7F);
    send_key(1'b1, 1'b0, 8'h32);
    step(1);
    send_key(1'b1, 1'b0, 8'h21);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL b2b_press: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    send_key(1'b0, 1'b0, 8'h32);
    step(1);
    send_key(1'b0, 1'b0, 8'h21);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL b2b_release: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
  endtask

  task automatic test_reset_discard;
    bus.kb_cols = 8'h00;
    sb.push_back(7'h7B);
    sb.push_back(7'h7F);
    sb.push_back(7'h7F);
    sb.push_back(7'h7F);
    send_key(1'b1, 1'b0, 8'h15);
    step(3);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL hold_q: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    // Toggle (press W) in the reset cycle must be dropped.
    send_key(1'b1, 1'b0, 8'h1D);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL reset_toggle: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    step(5);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL reset_toggle_hold: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
    // Event latched, then reset before it is decoded.
    send_key(1'b1, 1'b0, 8'h1D);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(4);
    exp_rows = sb.pop_front();
    checks++;
    if (bus.kb_rows !== exp_rows) begin
      errors++;
      $display("FAIL reset_latched: kb_rows=%h expected=%h", bus.kb_rows, exp_rows);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.ps2_key = 11'h000;
    bus.dragon  = 1'b0;
    bus.kb_cols = 8'hFF;
    bus.joy_btn = 2'b00;
    test_reset();
    test_press_a();
    test_dragon();
    test_shift();
    test_ext();
    test_unmapped();
    test_joystick();
    test_ghost();
    test_back_to_back();
    test_reset_discard();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
